// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline stages.
//
// Contents:
//   INSTR_W, PC_W   : field widths of the instruction payload
//   PAYLOAD_W       : packed payload width (instr + pc + pc4)
//   skid_state_e    : fill state of a two-entry skid stage
//   state_occupancy : maps a skid state to its held-entry count

package pipe_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC_W      = 13;
  localparam int unsigned PAYLOAD_W = INSTR_W + 2 * PC_W;

  // The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] state_occupancy(input skid_state_e state);
    logic [1:0] occ;
    case (state)
      StOne:   occ = 2'd1;
      StFull:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter.
//
// Ports:
//   clk   : rising-edge clock
//   aclr  : asynchronous reset, active-low, clears the count
//   inc   : add one at the next edge unless already at all-ones
//   count : current count, holds at 2^CNT_W-1

module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_max;

  assign at_max = (count_q == {CNT_W{1'b1}});

  always_comb begin
    count_d = count_q;
    if (inc && !at_max) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages.
//
// Breaks the ready path: in_ready depends only on the registered fill state,
// so there is no combinational route from out_ready to in_ready. The main
// register always drives out_data; the skid register catches the payload
// accepted while the downstream stage is stalled.
//
// Ports:
//   clk       : rising-edge clock
//   aclr      : asynchronous reset, active-low
//   sclr      : synchronous flush, active-high, drops all held payloads
//   in_valid  : upstream payload offered
//   in_ready  : stage can accept a payload (state not FULL)
//   in_data   : upstream payload
//   out_valid : downstream payload offered (state not EMPTY)
//   out_ready : downstream accepts payload
//   out_data  : downstream payload, zero when EMPTY
//   occupancy : held entries, 0..2
//   stall_cnt : saturating count of edges with out_valid & !out_ready

module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PAYLOAD_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              sclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q;
  skid_state_e       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;

  logic in_xfer;
  logic out_xfer;
  logic stall_inc;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign stall_inc = out_valid & ~out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) state_d = StOne;
      end
      StOne: begin
        if (in_xfer && !out_xfer)      state_d = StFull;
        else if (!in_xfer && out_xfer) state_d = StEmpty;
      end
      StFull: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) state_d = StOne;
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any transfer in the same cycle.
    if (sclr) state_d = StEmpty;
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) main_d = in_data;
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d = in_data;
        end else if (out_xfer) begin
          // Clearing main keeps out_data at zero while EMPTY.
          main_d = '0;
        end
      end
      StFull: begin
        if (out_xfer) begin
          main_d = skid_q;
          skid_d = '0;
        end
      end
      default: begin
        main_d = '0;
        skid_d = '0;
      end
    endcase
    if (sclr) begin
      main_d = '0;
      skid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    out_data  = main_q;
    occupancy = state_occupancy(state_q);
  end

  // ---------------------------------------------------------------------------
  // Stall counter, not touched by sclr
  // ---------------------------------------------------------------------------
  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .aclr  (aclr),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule
